// File: rtl/ifu_pc_gen_pkg.sv
// Shared constants and counter helper for the instruction-fetch PC generator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ifu_pc_gen_pkg;

    localparam int              INS_BUS_A     = 32;
    localparam logic [31:0]     ZERO_WORD     = 32'h0000_0000;
    localparam logic            STOP          = 1'b1;
    localparam logic            NO_STOP       = 1'b0;
    localparam int              BTB_IDX_W_DEF = 4;

    // A freshly allocated entry starts weakly taken.
    localparam logic [1:0]      CTR_ALLOC     = 2'b10;

    // 2-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ifu_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Latency: lookup is combinational; an update becomes visible one edge later.
// Backpressure: none; updates are accepted every cycle regardless of stalls.
import ifu_pc_gen_pkg::*;

module ifu_btb #(
    parameter int BTB_IDX_W = BTB_IDX_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INS_BUS_A-1:0] lkp_pc_i,
    output logic                 lkp_taken_o,
    output logic [INS_BUS_A-1:0] lkp_target_o,
    input  logic                 upd_vld_i,
    input  logic [INS_BUS_A-1:0] upd_pc_i,
    input  logic [INS_BUS_A-1:0] upd_target_i,
    input  logic                 upd_taken_i
);

    localparam int ENTRIES = 1 << BTB_IDX_W;
    localparam int TAG_W   = INS_BUS_A - 2 - BTB_IDX_W;

    logic [ENTRIES-1:0]   valid_q;
    logic [TAG_W-1:0]     tag_q    [ENTRIES];
    logic [INS_BUS_A-1:0] target_q [ENTRIES];
    logic [1:0]           ctr_q    [ENTRIES];

    logic [BTB_IDX_W-1:0] lkp_idx;
    logic [TAG_W-1:0]     lkp_tag;
    logic                 lkp_hit;
    logic [BTB_IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0]     upd_tag;
    logic                 upd_hit;
    logic                 upd_wr;
    logic                 unused_pc_bits;

    assign lkp_idx = lkp_pc_i[2 +: BTB_IDX_W];
    assign lkp_tag = lkp_pc_i[INS_BUS_A-1 -: TAG_W];
    assign upd_idx = upd_pc_i[2 +: BTB_IDX_W];
    assign upd_tag = upd_pc_i[INS_BUS_A-1 -: TAG_W];

    // Word offset bits never select an entry.
    assign unused_pc_bits = ^{lkp_pc_i[1:0], upd_pc_i[1:0]};

    // Lookup reads the registered array, so a same-cycle update is not seen yet.
    always_comb begin
        lkp_hit      = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
        lkp_taken_o  = lkp_hit && ctr_q[lkp_idx][1];
        lkp_target_o = lkp_taken_o ? target_q[lkp_idx] : ZERO_WORD;
    end

    // Train on a hit; allocate only on a taken miss; reset discards the update.
    always_comb begin
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_wr  = upd_vld_i && !rst_i && (upd_hit || upd_taken_i);
    end

    // Valid bits are the only state that needs clearing on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (upd_wr) begin
            valid_q[upd_idx] <= 1'b1;
        end
    end

    // Entry payload: counter steps on a hit, restarts weakly taken on allocation.
    always_ff @(posedge clk_i) begin
        if (upd_wr) begin
            tag_q[upd_idx] <= upd_tag;
            ctr_q[upd_idx] <= upd_hit ? ctr_next(ctr_q[upd_idx], upd_taken_i) : CTR_ALLOC;
            if (upd_taken_i) begin
                target_q[upd_idx] <= upd_target_i;
            end
        end
    end

endmodule

// File: rtl/ifu_pc_gen.sv
// Fetch PC register with BTB-predicted next PC and flush/redirect priority mux.
// Latency: flush/redirect reaches pc_o one edge later; prediction is same-cycle.
// Backpressure: stall_i[0] holds the PC; flush and redirect override the stall.
import ifu_pc_gen_pkg::*;

module ifu_pc_gen #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = BTB_IDX_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    input  logic        branch_redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        bu_valid_i,
    input  logic [31:0] bu_pc_i,
    input  logic [31:0] bu_target_i,
    input  logic        bu_taken_i,
    output logic [31:0] pc_o,
    output logic        ce_o,
    output logic [31:0] next_pc_o,
    output logic        next_taken_o,
    output logic        branch_slot_end_o
);

    logic [31:0] pc_q;
    logic [31:0] pred_target;
    logic        pred_taken;
    logic        ce_q;
    logic        slot_end_q;
    logic        unused_stall_bits;

    // Only the PC-stage bit of the stall vector matters here.
    assign unused_stall_bits = ^stall_i[5:1];

    ifu_btb #(
        .BTB_IDX_W    (BTB_IDX_W)
    ) u_btb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .lkp_pc_i     (pc_q),
        .lkp_taken_o  (pred_taken),
        .lkp_target_o (pred_target),
        .upd_vld_i    (bu_valid_i),
        .upd_pc_i     (bu_pc_i),
        .upd_target_i (bu_target_i),
        .upd_taken_i  (bu_taken_i)
    );

    // Prediction depends only on the current PC and BTB contents.
    always_comb begin
        next_taken_o = pred_taken;
        next_pc_o    = pred_taken ? pred_target : (pc_q + 32'd4);
    end

    // PC priority: reset, flush, redirect, stall, then predicted advance.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            ce_q       <= 1'b0;
            slot_end_q <= 1'b0;
        end else begin
            ce_q <= 1'b1;
            if (flush_i) begin
                pc_q       <= new_pc_i;
                slot_end_q <= 1'b1;
            end else if (branch_redirect_i) begin
                pc_q       <= redirect_pc_i;
                slot_end_q <= 1'b1;
            end else if (stall_i[0] == NO_STOP) begin
                pc_q       <= next_pc_o;
                slot_end_q <= 1'b0;
            end
        end
    end

    assign pc_o              = pc_q;
    assign ce_o              = ce_q;
    assign branch_slot_end_o = slot_end_q;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// Randomized bench for ifu_pc_gen against a behavioural fetch/BTB model.
// Latency: one check pass per clock, prediction before the edge, state after.
// Backpressure: stall, flush and redirect are exercised directly and randomly.
module tb_ifu_pc_gen;
    import ifu_pc_gen_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          NENT   = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  stall_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        branch_redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        bu_valid_i = 1'b0;
    logic [31:0] bu_pc_i = '0;
    logic [31:0] bu_target_i = '0;
    logic        bu_taken_i = 1'b0;
    logic [31:0] pc_o;
    logic        ce_o;
    logic [31:0] next_pc_o;
    logic        next_taken_o;
    logic        branch_slot_end_o;

    always #5 clk_i = ~clk_i;

    ifu_pc_gen #(.RESET_PC(RST_PC), .BTB_IDX_W(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .new_pc_i          (new_pc_i),
        .branch_redirect_i (branch_redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .bu_valid_i        (bu_valid_i),
        .bu_pc_i           (bu_pc_i),
        .bu_target_i       (bu_target_i),
        .bu_taken_i        (bu_taken_i),
        .pc_o              (pc_o),
        .ce_o              (ce_o),
        .next_pc_o         (next_pc_o),
        .next_taken_o      (next_taken_o),
        .branch_slot_end_o (branch_slot_end_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: each slot remembers the branch address it learned from.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_bse;
    bit          m_known = 1'b0;
    bit          m_vld [NENT];
    logic [31:0] m_bpc [NENT];
    logic [31:0] m_tgt [NENT];
    int          m_ctr [NENT];

    function automatic int slot_of(input logic [31:0] a);
        return int'((a / 4) % NENT);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        int s = slot_of(a);
        return m_vld[s] && ((m_bpc[s] / (4 * NENT)) == (a / (4 * NENT)));
    endfunction

    function automatic bit m_taken();
        return m_hit(m_pc) && (m_ctr[slot_of(m_pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_next();
        return m_taken() ? m_tgt[slot_of(m_pc)] : m_pc + 32'd4;
    endfunction

    task automatic step(input bit rst, input bit stl, input bit fl, input logic [31:0] npc,
                        input bit br, input logic [31:0] rpc, input bit bv,
                        input logic [31:0] bpc, input logic [31:0] btg, input bit bt);
        logic [31:0] pred;
        int s;
        @(negedge clk_i);
        rst_i             = rst;
        stall_i           = {5'($urandom_range(0, 31)), (stl ? STOP : NO_STOP)};
        flush_i           = fl;
        new_pc_i          = npc;
        branch_redirect_i = br;
        redirect_pc_i     = rpc;
        bu_valid_i        = bv;
        bu_pc_i           = bpc;
        bu_target_i       = btg;
        bu_taken_i        = bt;
        #1;
        if (m_known) begin
            check_eq("next_taken", 32'(next_taken_o), 32'(m_taken()));
            check_eq("next_pc", next_pc_o, m_next());
        end
        pred = m_next();
        @(posedge clk_i);
        if (rst) begin
            m_pc = RST_PC; m_ce = 1'b0; m_bse = 1'b0; m_known = 1'b1;
            for (int k = 0; k < NENT; k++) m_vld[k] = 1'b0;
        end else begin
            m_ce = 1'b1;
            if (bv) begin
                s = slot_of(bpc);
                if (m_hit(bpc)) begin
                    m_ctr[s] = bt ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                  : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                    if (bt) m_tgt[s] = btg;
                end else if (bt) begin
                    m_vld[s] = 1'b1; m_bpc[s] = bpc; m_tgt[s] = btg; m_ctr[s] = 2;
                end
            end
            if (fl)       begin m_pc = npc;  m_bse = 1'b1; end
            else if (br)  begin m_pc = rpc;  m_bse = 1'b1; end
            else if (!stl) begin m_pc = pred; m_bse = 1'b0; end
        end
        #1;
        check_eq("pc", pc_o, m_pc);
        check_eq("ce", 32'(ce_o), 32'(m_ce));
        check_eq("slot_end", 32'(branch_slot_end_o), 32'(m_bse));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redirect(input logic [31:0] a);
        step(0, 0, 0, 0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic train(input logic [31:0] a, input logic [31:0] t, input bit tk);
        step(0, 1, 0, 0, 0, 0, 1, a, t, tk);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FF00 + 32'($urandom_range(0, 63)) * 4;
        return 32'($urandom_range(0, 63)) * 4;
    endfunction

    initial begin
        // Reset state and sequential fetch.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_pc", pc_o, RST_PC);
        check_eq("rst_ce", 32'(ce_o), 32'd0);
        check_eq("rst_slot_end", 32'(branch_slot_end_o), 32'd0);
        check_eq("rst_next_pc", next_pc_o, RST_PC + 32'd4);
        check_eq("rst_next_taken", 32'(next_taken_o), 32'd0);
        repeat (3) idle();
        check_eq("seq_pc", pc_o, 32'd12);
        check_eq("seq_ce", 32'(ce_o), 32'd1);

        // Train a taken branch at 0x10 -> 0x40.
        train(32'h10, 32'h40, 1);
        redirect(32'h10);
        check_eq("trained_next_pc", next_pc_o, 32'h40);
        check_eq("trained_taken", 32'(next_taken_o), 32'd1);
        idle();
        check_eq("follow_target", pc_o, 32'h40);

        // Two not-taken updates drop it below the taken threshold.
        train(32'h10, 32'h0, 0);
        train(32'h10, 32'h0, 0);
        redirect(32'h10);
        check_eq("untrained_next_pc", next_pc_o, 32'h14);

        // Saturation: 0 -> 3 (held), one not-taken -> 2, still taken.
        repeat (5) train(32'h10, 32'h40, 1);
        train(32'h10, 32'h0, 0);
        redirect(32'h10);
        check_eq("sat_taken", 32'(next_taken_o), 32'd1);

        // Flush beats redirect, both beat the stall.
        step(0, 1, 1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
        check_eq("flush_pc", pc_o, 32'h100);
        check_eq("flush_slot_end", 32'(branch_slot_end_o), 32'd1);

        // Stall holds PC and slot-end, then resumes.
        redirect(32'h20);
        repeat (3) begin
            step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            check_eq("stall_pc", pc_o, 32'h20);
            check_eq("stall_slot_end", 32'(branch_slot_end_o), 32'd1);
        end
        idle();
        check_eq("resume_pc", pc_o, 32'h24);
        check_eq("resume_slot_end", 32'(branch_slot_end_o), 32'd0);

        // Sequential PC wraps at the top of the address space.
        redirect(32'hFFFF_FFFC);
        check_eq("wrap_next_pc", next_pc_o, 32'h0);

        // Reset mid-run forgets training; a same-cycle update is dropped.
        redirect(32'h10);
        check_eq("pre_rst_taken", 32'(next_taken_o), 32'd1);
        step(1, 0, 0, 0, 0, 0, 1, 32'h10, 32'h40, 1);
        check_eq("mid_rst_pc", pc_o, RST_PC);
        idle();
        redirect(32'h10);
        check_eq("post_rst_taken", 32'(next_taken_o), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [31:0] bpc;
            r   = $urandom_range(0, 999);
            bpc = ($urandom_range(0, 1) == 1) ? m_pc : rand_addr();
            step(r < 5,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 19) == 0, rand_addr(),
                 $urandom_range(0, 9) == 0, rand_addr(),
                 $urandom_range(0, 9) < 4, bpc, rand_addr(),
                 $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
